// File: rtl/mem_stage_pkg.sv
// Shared EX/MS/WB bus layouts and load-op encoding for the memory-access stage.
// Field order of the packed structs is the wire order of the pipeline buses.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 157;
    localparam int MS_TO_WS_BUS_WD = 117;

    // load_op is one-hot {lb, lbu, lh, lhu, lw, lwl, lwr}
    localparam int LD_LB  = 6;
    localparam int LD_LBU = 5;
    localparam int LD_LH  = 4;
    localparam int LD_LHU = 3;
    localparam int LD_LW  = 2;
    localparam int LD_LWL = 1;
    localparam int LD_LWR = 0;

    typedef struct packed {
        logic        inst_eret;
        logic        bd;
        logic        mtc0_we;
        logic [4:0]  cp0_addr;
        logic        res_from_cp0;
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
    } cp0_info_t;

    typedef struct packed {
        cp0_info_t   cp0;
        logic [6:0]  load_op;
        logic        mem_req;
        logic [31:0] rt_value;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        cp0_info_t   cp0;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side signal bundle of the memory-access stage: EX->MS, MS->WB,
// data-bus response, flush and decode bypass.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic                       es_req_outstanding;
    logic                       ws_ex;
    logic                       ms_ex;
    logic                       ms_fwd_valid;
    logic [4:0]                 ms_fwd_dest;
    logic [31:0]                ms_fwd_data;
    logic                       ms_fwd_block;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok,
               data_sram_rdata, es_req_outstanding, ws_ex,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex,
               ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_block
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok,
               data_sram_rdata, es_req_outstanding, ws_ex,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex,
               ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_block
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: byte/halfword extract with extension and
// the little-endian lwl/lwr merge with the old rt value.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [6:0]  load_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_value,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] lwl_s;
    logic [31:0] lwr_s;

    // Select the addressed byte and the lwl/lwr merges by byte offset.
    always_comb begin
        byte_s = 8'h00;
        lwl_s  = 32'h0000_0000;
        lwr_s  = 32'h0000_0000;
        case (offset)
            2'd0: begin
                byte_s = rdata[7:0];
                lwl_s  = {rdata[7:0], rt_value[23:0]};
                lwr_s  = rdata;
            end
            2'd1: begin
                byte_s = rdata[15:8];
                lwl_s  = {rdata[15:0], rt_value[15:0]};
                lwr_s  = {rt_value[31:24], rdata[31:8]};
            end
            2'd2: begin
                byte_s = rdata[23:16];
                lwl_s  = {rdata[23:0], rt_value[7:0]};
                lwr_s  = {rt_value[31:16], rdata[31:16]};
            end
            2'd3: begin
                byte_s = rdata[31:24];
                lwl_s  = rdata;
                lwr_s  = {rt_value[31:8], rdata[31:24]};
            end
            default: begin
                byte_s = 8'h00;
                lwl_s  = 32'h0000_0000;
                lwr_s  = 32'h0000_0000;
            end
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // One-hot load_op picks the final form; a plain lw passes rdata through.
    always_comb begin
        result = rdata;
        if (load_op[LD_LB]) begin
            result = ext8(byte_s, 1'b1);
        end else if (load_op[LD_LBU]) begin
            result = ext8(byte_s, 1'b0);
        end else if (load_op[LD_LH]) begin
            result = ext16(half_s, 1'b1);
        end else if (load_op[LD_LHU]) begin
            result = ext16(half_s, 1'b0);
        end else if (load_op[LD_LWL]) begin
            result = lwl_s;
        end else if (load_op[LD_LWR]) begin
            result = lwr_s;
        end else begin
            result = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: holds the EX->MS bus, waits for the data-bus
// response, aligns load data and drops responses owned by flushed instructions.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus_if
);

    logic        ms_valid_r;
    es_to_ms_t   ms_bus_r;
    logic        buf_valid_r;
    logic [31:0] buf_data_r;
    logic [1:0]  discard_cnt_r;
    logic [1:0]  discard_nxt_s;
    logic [2:0]  discard_sum_s;

    logic        ms_waiting_s;
    logic        own_data_ok_s;
    logic        ms_ready_go_s;
    logic        ms_allowin_s;
    logic        ms_is_load_s;
    logic [31:0] load_data_s;
    logic [31:0] load_result_s;
    logic [31:0] final_result_s;
    ms_to_ws_t   ms_out_s;

    assign ms_waiting_s   = ms_valid_r & ms_bus_r.mem_req & ~buf_valid_r;
    assign own_data_ok_s  = bus_if.data_sram_data_ok & (discard_cnt_r == 2'd0);
    assign ms_ready_go_s  = ~ms_waiting_s | own_data_ok_s;
    assign ms_allowin_s   = ~ms_valid_r | (ms_ready_go_s & bus_if.ws_allowin);
    assign ms_is_load_s   = |ms_bus_r.load_op;
    assign load_data_s    = buf_valid_r ? buf_data_r : bus_if.data_sram_rdata;

    mem_stage_load_align u_load_align (
        .load_op  (ms_bus_r.load_op),
        .offset   (ms_bus_r.alu_result[1:0]),
        .rdata    (load_data_s),
        .rt_value (ms_bus_r.rt_value),
        .result   (load_result_s)
    );

    assign final_result_s = ms_is_load_s ? load_result_s : ms_bus_r.alu_result;

    assign ms_out_s.cp0          = ms_bus_r.cp0;
    assign ms_out_s.gr_we        = ms_bus_r.gr_we;
    assign ms_out_s.dest         = ms_bus_r.dest;
    assign ms_out_s.final_result = final_result_s;
    assign ms_out_s.pc           = ms_bus_r.pc;

    assign bus_if.ms_allowin     = ms_allowin_s;
    assign bus_if.ms_to_ws_valid = ms_valid_r & ms_ready_go_s;
    assign bus_if.ms_to_ws_bus   = ms_out_s;
    assign bus_if.ms_ex          = ms_valid_r & (ms_bus_r.cp0.ex | ms_bus_r.cp0.inst_eret);
    assign bus_if.ms_fwd_valid   = ms_valid_r & ms_bus_r.gr_we;
    assign bus_if.ms_fwd_dest    = ms_valid_r ? ms_bus_r.dest : 5'd0;
    assign bus_if.ms_fwd_data    = ms_valid_r ? final_result_s : 32'h0000_0000;
    assign bus_if.ms_fwd_block   = ms_valid_r &
                                   ((ms_is_load_s & ~ms_ready_go_s) | ms_bus_r.cp0.res_from_cp0);

    // Stage valid bit; a flush from WB wins over any handoff.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_r <= 1'b0;
        end else if (bus_if.ws_ex) begin
            ms_valid_r <= 1'b0;
        end else if (ms_allowin_s) begin
            ms_valid_r <= bus_if.es_to_ms_valid;
        end else begin
            ms_valid_r <= ms_valid_r;
        end
    end

    // EX->MS bus register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_bus_r <= '0;
        end else if (bus_if.es_to_ms_valid & ms_allowin_s) begin
            ms_bus_r <= es_to_ms_t'(bus_if.es_to_ms_bus);
        end else begin
            ms_bus_r <= ms_bus_r;
        end
    end

    // Response buffer keeps our data while WB back-pressures.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= 32'h0000_0000;
        end else if (bus_if.ws_ex | (bus_if.ms_to_ws_valid & bus_if.ws_allowin)) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= buf_data_r;
        end else if (ms_waiting_s & own_data_ok_s) begin
            buf_valid_r <= 1'b1;
            buf_data_r  <= bus_if.data_sram_rdata;
        end else begin
            buf_valid_r <= buf_valid_r;
            buf_data_r  <= buf_data_r;
        end
    end

    // Net discard count: a response landing with the flush is MS's own, so it is not counted.
    always_comb begin
        discard_sum_s = {1'b0, discard_cnt_r};
        if (bus_if.ws_ex) begin
            discard_sum_s = discard_sum_s + {2'b00, ms_waiting_s & ~own_data_ok_s}
                                          + {2'b00, bus_if.es_req_outstanding};
        end else begin
            discard_sum_s = discard_sum_s;
        end
        if (bus_if.data_sram_data_ok & (discard_cnt_r != 2'd0)) begin
            discard_sum_s = discard_sum_s - 3'd1;
        end else begin
            discard_sum_s = discard_sum_s;
        end
        discard_nxt_s = (discard_sum_s > 3'd2) ? 2'd2 : discard_sum_s[1:0];
    end

    // Discard counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt_r <= 2'd0;
        end else begin
            discard_cnt_r <= discard_nxt_s;
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the execute stage and `wb_stage`. It latches the EX→MS bus and waits for the SRAM-like data-bus response of a load or store issued in EX. It aligns and sign-extends load data, including `lwl`/`lwr` merges, and hands the finished result to WB with the valid/allowin handshake. It also discards bus responses that belong to instructions flushed by a WB exception or `eret`.

## Interface
Parameters:
- `ES_TO_MS_BUS_WD`, 157, EX→MS bus width; field order MSB→LSB:
  - `inst_eret`, `bd`, `mtc0_we`, `cp0_addr[4:0]`, `res_from_cp0`, `ex`, `excode[4:0]`, `badvaddr[31:0]`
  - `load_op[6:0]`, one-hot {lb, lbu, lh, lhu, lw, lwl, lwr}
  - `mem_req`, a data request was accepted (addr_ok) in EX
  - `rt_value[31:0]`, `gr_we`, `dest[4:0]`, `alu_result[31:0]`, `pc[31:0]`
- `MS_TO_WS_BUS_WD`, 117, MS→WB bus; field order MSB→LSB:
  - `inst_eret`, `bd`, `mtc0_we`, `cp0_addr[4:0]`, `res_from_cp0`, `ex`, `excode[4:0]`, `badvaddr[31:0]`
  - `gr_we`, `dest[4:0]`, `final_result[31:0]`, `pc[31:0]`

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `ms_allowin` out 1: MS can accept from EX.
- `es_to_ms_valid` in 1
- `es_to_ms_bus` in ES_TO_MS_BUS_WD
- `ws_allowin` in 1
- `ms_to_ws_valid` out 1
- `ms_to_ws_bus` out MS_TO_WS_BUS_WD
- `data_sram_data_ok` in 1: in-order response strobe.
- `data_sram_rdata` in 32
- `es_req_outstanding` in 1: EX holds an accepted request whose response has not yet been consumed.
- `ws_ex` in 1: flush from WB (exception or eret).
- `ms_ex` out 1: `ms_valid & (ex | inst_eret)`; EX suppresses new requests while it is high.
- `ms_fwd_valid` out 1, `ms_fwd_dest` out 5, `ms_fwd_data` out 32: bypass to decode.
- `ms_fwd_block` out 1: MS holds a load whose data is not yet final; decode stalls.

## Operation
- Pipeline register `ms_valid`:
  - Cleared on reset or `ws_ex`.
  - Otherwise loads `es_to_ms_valid` when `ms_allowin`.
  - The bus register loads when `es_to_ms_valid & ms_allowin`.
- `ms_waiting = ms_valid & mem_req & !buf_valid`.
- `ms_ready_go = !ms_waiting | (data_sram_data_ok & discard_cnt==0)`.
- `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_valid = ms_valid & ms_ready_go`.
- Response buffer:
  - A `data_ok` arriving with `discard_cnt==0` while `ms_waiting` is captured into `buf_data`, and `buf_valid` is set.
  - `buf_valid` clears when the instruction moves to WB or on `ws_ex`.
  - Load data = `buf_valid ? buf_data : data_sram_rdata`.
- Discard counter `discard_cnt` (2 bits):
  - On `ws_ex` it adds `ms_waiting + es_req_outstanding`.
  - It decrements on each `data_ok` while nonzero; those responses are ignored.
  - Add and decrement in the same cycle are applied together (net value).
- Load alignment, using `alu_result[1:0]` as byte offset `a`:
  - lb/lbu: byte `a`, sign- or zero-extended.
  - lh/lhu: halfword `a[1]`, sign- or zero-extended.
  - lw: the word unchanged.
  - lwl: the high `(a+1)` bytes come from memory, the rest from `rt_value`.
  - lwr: the low `(4-a)` bytes come from memory, the rest from `rt_value`.
- `final_result` = aligned load data if any `load_op` bit is set, else `alu_result`. All other fields pass through unchanged.
- Stores: `mem_req=1` with `load_op==0`; MS waits for `data_ok` and forwards `alu_result`.
- Forwarding:
  - `ms_fwd_valid = ms_valid & gr_we`, and `ms_fwd_dest = dest`.
  - `ms_fwd_data = final_result`.
  - `ms_fwd_block = ms_valid & (|load_op) & !ms_ready_go`, also asserted when `res_from_cp0`.
- An instruction with `ex=1` arrives with `mem_req=0` and completes at once.

## Timing
- Reset values: `ms_valid`, `buf_valid` and `ms_ex` 0; `discard_cnt` 0; `ms_to_ws_valid` 0; `ms_allowin` 1; all forward outputs 0. The bus registers are don't-care.
- Latency, non-memory instruction: 1 cycle EX→WB handoff, no bubble, back-to-back throughput of 1 per cycle.
- Latency, load: completes in the cycle `data_ok` arrives, giving 1 cycle if the response comes in the first MS cycle.
- Back-pressure: with `ws_allowin=0` and data received, the buffer holds the data; there is no loss and no re-request.
- Simultaneous `ws_ex` and `data_ok`:
  - With `discard_cnt==0`, the response counts as MS's own and is dropped because MS is flushed.
  - The counter adds only `es_req_outstanding` in that case.
- Saturation: `discard_cnt` never exceeds 2, because the bus allows at most 2 outstanding requests.
- Reset mid-wait: all state clears immediately; any late `data_ok` is the system's responsibility.

## Structure
- Bus widths, field offsets and the `load_op` bit indices go in `mycpu.h`, shared with the EX and WB stages.
- One sub-module, `load_align`: purely combinational; inputs `load_op`, offset, rdata and `rt_value`; output is the result.

## Test plan
- ALU op: `alu_result=0x1234`, `dest=5` → WB sees `final_result=0x1234` one cycle after the handoff; `ms_fwd_valid=1` while in MS.
- lb/lhu/lwl/lwr, with `rdata=0x8899AABB` and `rt_value=0x11223344`:
  - lb at a=2 → `0xFFFFFF99`.
  - lhu at a=2 → `0x00008899`.
  - lwl at a=1 → `0xAABB3344`.
  - lwr at a=1 → `0x118899AA`.
- Load with `data_ok` 3 cycles late → `ms_fwd_block=1` and `ms_to_ws_valid=0` for 3 cycles, then the result is forwarded.
- Response arrives while `ws_allowin=0` for 2 cycles → the result is held, and the correct data is delivered when allowin rises.
- `ws_ex` while MS is waiting and `es_req_outstanding=1` → `discard_cnt=2`, the next two `data_ok` are ignored, and a subsequent load gets the third response.
- Simultaneous `ws_ex` and `data_ok` with `es_req_outstanding=0` → `discard_cnt` stays 0, and `ms_valid=0` next cycle.
